// File: rtl/noise_freq_lfsr.sv
// Noise channel period timer and 15-bit LFSR.
// The timer counts NNF..0 on enabled edges; each zero-crossing reloads it and shifts the LFSR once.
module noise_freq_lfsr (
    input  logic        CLK,
    input  logic        RES,
    input  logic        ACLK_EN,
    input  logic [10:0] NNF,
    input  logic        NMODE,
    output logic [10:0] TIMER,
    output logic [14:0] LFSR,
    output logic        RNDOUT,
    output logic        SHIFT
);

    localparam int unsigned TIMER_W = 11;
    localparam int unsigned LFSR_W  = 15;
    localparam logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(1);

    logic [TIMER_W-1:0] r_timer;
    logic [LFSR_W-1:0]  r_lfsr;
    logic               r_shift;

    logic               w_reload;
    logic               w_fb;
    logic [LFSR_W-1:0]  w_lfsr_next;

    assign w_reload = (r_timer == TIMER_W'(0));

    // Tap select is sampled on the shift edge only; all-zero state is forced back to the seed.
    always_comb begin
        w_fb        = r_lfsr[0] ^ (NMODE ? r_lfsr[6] : r_lfsr[1]);
        w_lfsr_next = {w_fb, r_lfsr[LFSR_W-1:1]};
        if (r_lfsr == LFSR_W'(0)) begin
            w_lfsr_next = LFSR_SEED;
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            r_timer <= TIMER_W'(0);
            r_lfsr  <= LFSR_SEED;
            r_shift <= 1'b0;
        end else if (ACLK_EN) begin
            if (w_reload) begin
                r_timer <= NNF;
                r_lfsr  <= w_lfsr_next;
                r_shift <= 1'b1;
            end else begin
                r_timer <= r_timer - TIMER_W'(1);
                r_shift <= 1'b0;
            end
        end else begin
            r_shift <= 1'b0;
        end
    end

    assign TIMER  = r_timer;
    assign LFSR   = r_lfsr;
    assign RNDOUT = r_lfsr[0];
    assign SHIFT  = r_shift;

endmodule

// File: tb/tb_noise_freq_lfsr.sv
// Directed bench for noise_freq_lfsr: reset, reload timing, gating, NNF/NMODE changes, sequence periods.
module tb_noise_freq_lfsr;

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic        ACLK_EN = 1'b0;
    logic [10:0] NNF = 11'd0;
    logic        NMODE = 1'b0;
    logic [10:0] TIMER;
    logic [14:0] LFSR;
    logic        RNDOUT;
    logic        SHIFT;

    int n_checks = 0;
    int n_errors = 0;

    logic [10:0] m_timer = 11'd0;
    logic [14:0] m_lfsr  = 15'h0001;
    logic        m_shift = 1'b0;

    noise_freq_lfsr dut (
        .CLK(CLK), .RES(RES), .ACLK_EN(ACLK_EN), .NNF(NNF), .NMODE(NMODE),
        .TIMER(TIMER), .LFSR(LFSR), .RNDOUT(RNDOUT), .SHIFT(SHIFT)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] lfsr_step(input logic [14:0] l, input logic mode);
        logic fb;
        if (l == 15'h0000) return 15'h0001;
        fb = l[0] ^ (mode ? l[6] : l[1]);
        return {fb, l[14:1]};
    endfunction

    // One clock: drive inputs, advance the reference, compare all outputs after the edge.
    task automatic step(input logic res, input logic en, input string tag);
        RES = res;
        ACLK_EN = en;
        @(posedge CLK);
        if (res) begin
            m_timer = 11'd0; m_lfsr = 15'h0001; m_shift = 1'b0;
        end else if (en) begin
            if (m_timer == 11'd0) begin
                m_timer = NNF; m_lfsr = lfsr_step(m_lfsr, NMODE); m_shift = 1'b1;
            end else begin
                m_timer = m_timer - 11'd1; m_shift = 1'b0;
            end
        end else begin
            m_shift = 1'b0;
        end
        @(negedge CLK);
        check_eq({tag, ".timer"},  32'(TIMER),  32'(m_timer));
        check_eq({tag, ".lfsr"},   32'(LFSR),   32'(m_lfsr));
        check_eq({tag, ".shift"},  32'(SHIFT),  32'(m_shift));
        check_eq({tag, ".rndout"}, 32'(RNDOUT), 32'(m_lfsr[0]));
    endtask

    initial begin
        logic [10:0] exp_t [10];
        logic [14:0] exp_l [10];
        logic        exp_s [10];
        logic [14:0] first_val;
        logic [14:0] saved;
        int          last_shift;
        int          n_shifts;
        int          cnt;
        logic        prev_shift;
        logic        found;

        exp_t = '{11'd2, 11'd1, 11'd0, 11'd2, 11'd1, 11'd0, 11'd2, 11'd1, 11'd0, 11'd2};
        exp_s = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_l = '{15'h4000, 15'h4000, 15'h4000, 15'h2000, 15'h2000, 15'h2000,
                  15'h1000, 15'h1000, 15'h1000, 15'h0800};

        @(negedge CLK);
        step(1'b1, 1'b0, "reset");
        check_eq("reset.timer_hard",  32'(TIMER),  32'd0);
        check_eq("reset.lfsr_hard",   32'(LFSR),   32'h0001);
        check_eq("reset.rndout_hard", 32'(RNDOUT), 32'd1);

        // First shift and reload cadence with NNF=2
        NNF = 11'd2; NMODE = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, "first");
            check_eq($sformatf("first.e%0d.timer_hard", i + 1), 32'(TIMER), 32'(exp_t[i]));
            check_eq($sformatf("first.e%0d.shift_hard", i + 1), 32'(SHIFT), 32'(exp_s[i]));
            check_eq($sformatf("first.e%0d.lfsr_hard",  i + 1), 32'(LFSR),  32'(exp_l[i]));
        end
        check_eq("first.rndout_hard", 32'(RNDOUT), 32'd0);

        // Reset mid-count at TIMER=7
        step(1'b1, 1'b0, "rmc.rst");
        NNF = 11'd10;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, "rmc.count");
        check_eq("rmc.pre_timer", 32'(TIMER), 32'd7);
        step(1'b1, 1'b1, "rmc.pulse");
        check_eq("rmc.timer_hard",  32'(TIMER),  32'd0);
        check_eq("rmc.lfsr_hard",   32'(LFSR),   32'h0001);
        check_eq("rmc.rndout_hard", 32'(RNDOUT), 32'd1);
        check_eq("rmc.shift_hard",  32'(SHIFT),  32'd0);

        // Gating: enable on alternate clocks, NNF=5
        NNF = 11'd5;
        last_shift = -1; n_shifts = 0; prev_shift = 1'b0;
        for (int i = 0; i < 26; i++) begin
            step(1'b0, (i % 2 == 0), "gate");
            if (SHIFT) begin
                if (last_shift >= 0) check_eq("gate.interval", 32'(i - last_shift), 32'd12);
                last_shift = i;
                n_shifts++;
            end
            if (prev_shift) check_eq("gate.no_double", 32'(SHIFT), 32'd0);
            prev_shift = SHIFT;
        end
        check_eq("gate.n_shifts", 32'(n_shifts), 32'd3);

        // NNF change mid-count is ignored until the next reload
        step(1'b1, 1'b0, "nnf.rst");
        NNF = 11'd10;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, "nnf.count");
        check_eq("nnf.pre_timer", 32'(TIMER), 32'd7);
        NNF = 11'd0;
        for (int i = 6; i >= 0; i--) begin
            step(1'b0, 1'b1, "nnf.drain");
            check_eq($sformatf("nnf.drain%0d", i), 32'(TIMER), 32'(i));
            check_eq("nnf.drain_noshift", 32'(SHIFT), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, "nnf.fast");
            check_eq("nnf.fast_timer", 32'(TIMER), 32'd0);
            check_eq("nnf.fast_shift", 32'(SHIFT), 32'd1);
        end

        // Short-mode sequence period
        step(1'b1, 1'b0, "short.rst");
        NNF = 11'd0; NMODE = 1'b1;
        step(1'b0, 1'b1, "short.first");
        first_val = LFSR;
        check_eq("short.first_val", 32'(first_val), 32'h4000);
        cnt = 0; found = 1'b0;
        while (!found && cnt < 200) begin
            step(1'b0, 1'b1, "short.run");
            cnt++;
            if (LFSR == first_val) found = 1'b1;
        end
        check_eq("short.period", 32'(cnt), 32'd93);

        // Long-mode sequence period (lightweight loop, no per-cycle model)
        RES = 1'b1; ACLK_EN = 1'b0; NMODE = 1'b0;
        @(posedge CLK); @(negedge CLK);
        RES = 1'b0; ACLK_EN = 1'b1;
        @(posedge CLK); @(negedge CLK);
        first_val = LFSR;
        cnt = 0; found = 1'b0;
        while (!found && cnt < 40000) begin
            @(posedge CLK); @(negedge CLK);
            cnt++;
            if (LFSR == first_val) found = 1'b1;
        end
        check_eq("long.period", 32'(cnt), 32'd32767);

        // Mode switch between shifts
        step(1'b1, 1'b0, "mode.rst");
        m_timer = 11'd0; m_lfsr = 15'h0001; m_shift = 1'b0;
        NNF = 11'd2; NMODE = 1'b0;
        n_shifts = 0;
        while (n_shifts < 5) begin
            step(1'b0, 1'b1, "mode.long");
            if (SHIFT) n_shifts++;
        end
        check_eq("mode.after5", 32'(LFSR), 32'h0400);
        saved = LFSR;
        NMODE = 1'b1;
        step(1'b0, 1'b1, "mode.hold1");
        check_eq("mode.hold1_lfsr", 32'(LFSR), 32'(saved));
        step(1'b0, 1'b1, "mode.hold2");
        check_eq("mode.hold2_lfsr", 32'(LFSR), 32'(saved));
        step(1'b0, 1'b1, "mode.shift");
        check_eq("mode.shift_pulse", 32'(SHIFT), 32'd1);
        check_eq("mode.shift_ref",   32'(LFSR),  32'(lfsr_step(saved, 1'b1)));
        for (int i = 0; i < 60; i++) step(1'b0, 1'b1, "mode.run");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
